// File: rtl/simmem_resp_delay.sv
// simmem_resp_delay: per-ID programmable response delay buffer, in-order within an ID, out-of-order across IDs
// ports: clk_i/rst_i clock and async reset; cfg_* delay table write; in_* accepted beats (valid/ready);
//        out_* released beats (valid/ready); occupancy_o count of unreleased beats
module simmem_resp_delay #(
  parameter int DataWidth  = 64,
  parameter int IdWidth    = 4,
  parameter int Depth      = 16,
  parameter int DelayWidth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_we_i,
  input  logic [IdWidth-1:0]         cfg_id_i,
  input  logic [DelayWidth-1:0]      cfg_delay_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IdWidth-1:0]         in_id_i,
  input  logic [DataWidth-1:0]       in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [IdWidth-1:0]         out_id_o,
  output logic [DataWidth-1:0]       out_data_o,
  output logic [$clog2(Depth):0]     occupancy_o
);
  localparam int PW = $clog2(Depth) + 1;
  localparam int IW = PW - 1;
  localparam int NI = 2 ** IdWidth;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, occ_q, occ_d;
  logic [Depth-1:0]      vld_q;
  logic [IdWidth-1:0]    id_q   [Depth];
  logic [DataWidth-1:0]  data_q [Depth];
  logic [DelayWidth-1:0] cnt_q  [Depth];
  logic [DelayWidth-1:0] tbl_q  [NI];
  logic                  lock_q, lock_d;
  logic [IW-1:0]         lock_idx_q, sel_idx, pres_idx, idx;
  logic [NI-1:0]         seen;
  logic                  found, full, empty, acc, rel;
  // walk from head; an ID seen on an older valid slot blocks all younger slots of that ID
  always_comb begin
    found = 1'b0;
    sel_idx = '0;
    seen = '0;
    idx = '0;
    for (int k = 0; k < Depth; k++) begin
      idx = head_q[IW-1:0] + IW'(k);
      if (vld_q[idx]) begin
        if (!found && cnt_q[idx] == '0 && !seen[id_q[idx]]) begin
          found = 1'b1;
          sel_idx = idx;
        end
        seen[id_q[idx]] = 1'b1;
      end
    end
  end
  assign empty       = head_q == tail_q;
  assign full        = (head_q[PW-1] != tail_q[PW-1]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
  assign in_ready_o  = !full;
  assign pres_idx    = lock_q ? lock_idx_q : sel_idx;
  assign out_valid_o = lock_q || found;
  assign out_id_o    = out_valid_o ? id_q[pres_idx] : '0;
  assign out_data_o  = out_valid_o ? data_q[pres_idx] : '0;
  assign occupancy_o = occ_q;
  assign acc         = in_valid_i && !full;
  assign rel         = out_valid_o && out_ready_i;
  always_comb begin
    tail_d = acc ? tail_q + PW'(1) : tail_q;
    head_d = (!empty && !vld_q[head_q[IW-1:0]]) ? head_q + PW'(1) : head_q;
    occ_d  = occ_q + PW'(acc) - PW'(rel);
    lock_d = out_valid_o && !out_ready_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      vld_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      for (int i = 0; i < NI; i++) tbl_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      lock_q     <= lock_d;
      lock_idx_q <= pres_idx;
      if (cfg_we_i) tbl_q[cfg_id_i] <= cfg_delay_i;
      for (int i = 0; i < Depth; i++) begin
        if (acc && tail_q[IW-1:0] == IW'(i)) begin
          vld_q[i]  <= 1'b1;
          id_q[i]   <= in_id_i;
          data_q[i] <= in_data_i;
          cnt_q[i]  <= tbl_q[in_id_i];
        end else begin
          if (rel && pres_idx == IW'(i)) vld_q[i] <= 1'b0;
          if (vld_q[i] && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_simmem_resp_delay.sv
// tb_simmem_resp_delay: directed self-checking bench for simmem_resp_delay
module tb_simmem_resp_delay;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_id_i = '0;
  logic [7:0]  cfg_delay_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [3:0]  in_id_i = '0;
  logic [63:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [3:0]  out_id_o;
  logic [63:0] out_data_o;
  logic [4:0]  occupancy_o;
  int vecs = 0;
  int errs = 0;
  simmem_resp_delay dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_id_i(cfg_id_i), .cfg_delay_i(cfg_delay_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_id_i(in_id_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_id_o(out_id_o), .out_data_o(out_data_o),
    .occupancy_o(occupancy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic cfg(input logic [3:0] id, input logic [7:0] d);
    cfg_we_i = 1'b1;
    cfg_id_i = id;
    cfg_delay_i = d;
    tick();
    cfg_we_i = 1'b0;
  endtask
  task automatic push(input logic [3:0] id, input logic [63:0] data);
    vecs++;
    if (in_ready_o !== 1'b1) begin errs++; $display("FAIL push_ready id=%0h got=%0b exp=1", id, in_ready_o); end
    in_valid_i = 1'b1;
    in_id_i = id;
    in_data_i = data;
    tick();
    in_valid_i = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    vecs++;
    if (out_valid_o !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
    vecs++;
    if (in_ready_o !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_o); end
    vecs++;
    if (occupancy_o !== 5'd0) begin errs++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy_o); end
    vecs++;
    if (out_id_o !== 4'd0 || out_data_o !== 64'd0) begin errs++; $display("FAIL reset_out_zero got=%0h/%0h exp=0/0", out_id_o, out_data_o); end
    tick();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
  endtask
  task automatic test_single();
    cfg(4'd3, 8'd5);
    push(4'd3, 64'hA5);
    vecs++;
    if (occupancy_o !== 5'd1 || out_valid_o !== 1'b0) begin errs++; $display("FAIL single_t1 got occ=%0d valid=%0b exp occ=1 valid=0", occupancy_o, out_valid_o); end
    repeat (4) tick();
    vecs++;
    if (out_valid_o !== 1'b0) begin errs++; $display("FAIL single_early got=%0b exp=0", out_valid_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd3 || out_data_o !== 64'hA5) begin errs++; $display("FAIL single_out got valid=%0b id=%0h data=%0h exp 1/3/a5", out_valid_o, out_id_o, out_data_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 5'd0) begin errs++; $display("FAIL single_done got valid=%0b occ=%0d exp 0/0", out_valid_o, occupancy_o); end
    repeat (3) tick();
  endtask
  task automatic test_overtake();
    cfg(4'd1, 8'd20);
    cfg(4'd2, 8'd2);
    push(4'd1, 64'h11);
    push(4'd2, 64'h22);
    tick();
    tick();
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd2 || out_data_o !== 64'h22) begin errs++; $display("FAIL overtake_first got valid=%0b id=%0h data=%0h exp 1/2/22", out_valid_o, out_id_o, out_data_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 5'd1) begin errs++; $display("FAIL overtake_gap got valid=%0b occ=%0d exp 0/1", out_valid_o, occupancy_o); end
    repeat (15) tick();
    vecs++;
    if (out_valid_o !== 1'b0) begin errs++; $display("FAIL overtake_early got=%0b exp=0", out_valid_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd1 || out_data_o !== 64'h11) begin errs++; $display("FAIL overtake_second got valid=%0b id=%0h data=%0h exp 1/1/11", out_valid_o, out_id_o, out_data_o); end
    repeat (4) tick();
  endtask
  task automatic test_same_id();
    cfg(4'd4, 8'd10);
    push(4'd4, 64'hAAAA);
    cfg(4'd4, 8'd0);
    push(4'd4, 64'hBBBB);
    vecs++;
    if (out_valid_o !== 1'b0) begin errs++; $display("FAIL same_id_blocked got=%0b exp=0", out_valid_o); end
    repeat (7) tick();
    vecs++;
    if (out_valid_o !== 1'b0) begin errs++; $display("FAIL same_id_early got=%0b exp=0", out_valid_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'hAAAA) begin errs++; $display("FAIL same_id_a got valid=%0b data=%0h exp 1/aaaa", out_valid_o, out_data_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'hBBBB) begin errs++; $display("FAIL same_id_b got valid=%0b data=%0h exp 1/bbbb", out_valid_o, out_data_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b0) begin errs++; $display("FAIL same_id_done got=%0b exp=0", out_valid_o); end
    repeat (3) tick();
  endtask
  task automatic test_lock();
    out_ready_i = 1'b0;
    cfg(4'd5, 8'd6);
    cfg(4'd6, 8'd0);
    push(4'd5, 64'h55);
    push(4'd6, 64'h66);
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd6) begin errs++; $display("FAIL lock_young got valid=%0b id=%0h exp 1/6", out_valid_o, out_id_o); end
    repeat (6) tick();
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd6 || out_data_o !== 64'h66) begin errs++; $display("FAIL lock_hold got valid=%0b id=%0h data=%0h exp 1/6/66", out_valid_o, out_id_o, out_data_o); end
    out_ready_i = 1'b1;
    tick();
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd5 || out_data_o !== 64'h55) begin errs++; $display("FAIL lock_old got valid=%0b id=%0h data=%0h exp 1/5/55", out_valid_o, out_id_o, out_data_o); end
    tick();
    vecs++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 5'd0) begin errs++; $display("FAIL lock_done got valid=%0b occ=%0d exp 0/0", out_valid_o, occupancy_o); end
    repeat (3) tick();
  endtask
  task automatic test_full_holes();
    int n;
    out_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) cfg(4'(k), k == 0 ? 8'd30 : (k == 5 ? 8'd0 : 8'd200));
    for (int k = 0; k < 16; k++) push(4'(k), 64'h100 + 64'(k));
    vecs++;
    if (in_ready_o !== 1'b0 || occupancy_o !== 5'd16) begin errs++; $display("FAIL full_state got ready=%0b occ=%0d exp 0/16", in_ready_o, occupancy_o); end
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd5) begin errs++; $display("FAIL full_slot5 got valid=%0b id=%0h exp 1/5", out_valid_o, out_id_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    vecs++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 5'd15) begin errs++; $display("FAIL hole_release got valid=%0b occ=%0d exp 0/15", out_valid_o, occupancy_o); end
    repeat (3) tick();
    vecs++;
    if (in_ready_o !== 1'b0) begin errs++; $display("FAIL hole_not_free got=%0b exp=0", in_ready_o); end
    n = 0;
    while (out_valid_o !== 1'b1 && n < 60) begin tick(); n++; end
    vecs++;
    if (out_valid_o !== 1'b1 || out_id_o !== 4'd0 || out_data_o !== 64'h100) begin errs++; $display("FAIL head_beat got valid=%0b id=%0h data=%0h exp 1/0/100", out_valid_o, out_id_o, out_data_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    vecs++;
    if (in_ready_o !== 1'b0) begin errs++; $display("FAIL head_pending got=%0b exp=0", in_ready_o); end
    tick();
    vecs++;
    if (in_ready_o !== 1'b1 || occupancy_o !== 5'd14) begin errs++; $display("FAIL head_passed got ready=%0b occ=%0d exp 1/14", in_ready_o, occupancy_o); end
  endtask
  task automatic test_async_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cfg(4'd9, 8'd50);
    for (int k = 0; k < 7; k++) push(4'd9, 64'h900 + 64'(k));
    vecs++;
    if (occupancy_o !== 5'd7) begin errs++; $display("FAIL async_pre_occ got=%0d exp=7", occupancy_o); end
    #2;
    rst_i = 1'b1;
    #1;
    vecs++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 5'd0 || in_ready_o !== 1'b1) begin errs++; $display("FAIL async_clear got valid=%0b occ=%0d ready=%0b exp 0/0/1", out_valid_o, occupancy_o, in_ready_o); end
    tick();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    push(4'd9, 64'hBEEF);
    vecs++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'hBEEF) begin errs++; $display("FAIL async_table_zero got valid=%0b data=%0h exp 1/beef", out_valid_o, out_data_o); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_overtake();
    test_same_id();
    test_lock();
    test_full_holes();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
